// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame checker.
//   state_t     : frame FSM states (IDLE, DATA, PAR)
//   PAR_EVEN/ODD: values of odd_mode selecting even / odd parity
//   cnt_width() : width of the bit-position counter for a given DATA_BITS
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // The counter has to hold the value DATA_BITS itself, so it needs
  // clog2(DATA_BITS+1) bits.
  function automatic int cnt_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   inc      : add one unless already all ones
//   clr      : force to zero; wins over inc
//   count    : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Serial parity frame checker. Deserialises frames of DATA_BITS data bits
// (LSB first) followed by one parity bit, checks even/odd parity and counts
// parity errors.
//   clk, rst    : clock, synchronous active-high reset
//   x, x_valid  : serial bit and its qualifier
//   sof         : start of frame (with x_valid); x becomes data bit 0
//   odd_mode    : parity sense, latched on data bit 0
//   clr_count   : clears err_count
//   z           : running parity of data bits received in the current frame
//   data_out    : last completed word
//   word_valid  : one-cycle pulse on frame completion
//   parity_err  : one-cycle pulse with word_valid when parity mismatches
//   frame_abort : one-cycle pulse when sof discards a partial frame
//   err_count   : saturating parity error count
//
// Handshake: x is consumed on every cycle where x_valid=1; there is no
// backpressure. All outputs are registered; pulses appear the cycle after
// the sample that caused them.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 sof,
  input  logic                 odd_mode,
  input  logic                 clr_count,
  output logic                 z,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 word_valid,
  output logic                 parity_err,
  output logic                 frame_abort,
  output logic [CNT_W-1:0]     err_count
);

  localparam int CW = cnt_width(DATA_BITS);

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic [DATA_BITS-1:0] shreg;
  logic                 mode_q;

  logic start;      // sampled bit is data bit 0 of a new frame
  logic abort;      // sof arrived while a frame was in progress
  logic data_take;  // sampled bit is a further data bit
  logic par_take;   // sampled bit is the parity bit
  logic frame_err;  // parity bit disagrees with the latched parity sense
  logic last_data;  // current data bit is the final one of the frame

  always_comb begin
    start     = x_valid && (sof || (state == IDLE));
    abort     = x_valid && sof && (state != IDLE);
    data_take = x_valid && !sof && (state == DATA);
    par_take  = x_valid && !sof && (state == PAR);
    // Even mode wants the parity bit equal to z, odd mode its inverse.
    frame_err = par_take && (x != (z ^ mode_q));
    cnt_inc   = cnt + 1'b1;
    last_data = (cnt_inc == CW'(DATA_BITS));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = (DATA_BITS == 1) ? PAR : DATA;
    end else if (data_take && last_data) begin
      state_next = PAR;
    end else if (par_take) begin
      state_next = IDLE;
    end
  end

  // Datapath: shift register, running parity, completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      shreg       <= '0;
      mode_q      <= PAR_EVEN;
      z           <= 1'b0;
      data_out    <= '0;
      word_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      word_valid  <= par_take;
      parity_err  <= frame_err;
      frame_abort <= abort;
      if (start) begin
        // Stale upper bits of shreg are overwritten before completion.
        shreg[0] <= x;
        z        <= x;
        mode_q   <= odd_mode;
        cnt      <= CW'(1);
      end else if (data_take) begin
        for (int i = 1; i < DATA_BITS; i++) begin
          if (cnt == CW'(i)) begin
            shreg[i] <= x;
          end
        end
        z   <= z ^ x;
        cnt <= cnt_inc;
      end else if (par_take) begin
        data_out <= shreg;
        z        <= 1'b0;
        cnt      <= '0;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (frame_err),
    .clr  (clr_count),
    .count(err_count)
  );

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker. Three instances:
//   dut_a : DATA_BITS=8, CNT_W=8
//   dut_b : DATA_BITS=8, CNT_W=2 (same inputs as dut_a)
//   dut_c : DATA_BITS=1, CNT_W=8 (own serial inputs, shared reset)
module tb_parity_frame_checker;
  import parity_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic x, x_valid, sof, odd_mode, clr_count;
  logic x1, x_valid1, sof1;

  logic       z_a, wv_a, pe_a, fa_a;
  logic [7:0] d_a, c_a;
  logic       z_b, wv_b, pe_b, fa_b;
  logic [7:0] d_b;
  logic [1:0] c_b;
  logic       z_c, wv_c, pe_c, fa_c;
  logic [0:0] d_c;
  logic [7:0] c_c;

  int tests = 0;
  int fails = 0;

  parity_frame_checker #(.DATA_BITS(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sof(sof),
    .odd_mode(odd_mode), .clr_count(clr_count), .z(z_a), .data_out(d_a),
    .word_valid(wv_a), .parity_err(pe_a), .frame_abort(fa_a), .err_count(c_a)
  );

  parity_frame_checker #(.DATA_BITS(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sof(sof),
    .odd_mode(odd_mode), .clr_count(clr_count), .z(z_b), .data_out(d_b),
    .word_valid(wv_b), .parity_err(pe_b), .frame_abort(fa_b), .err_count(c_b)
  );

  parity_frame_checker #(.DATA_BITS(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .x(x1), .x_valid(x_valid1), .sof(sof1),
    .odd_mode(PAR_EVEN), .clr_count(1'b0), .z(z_c), .data_out(d_c),
    .word_valid(wv_c), .parity_err(pe_c), .frame_abort(fa_c), .err_count(c_c)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit for one cycle, then idle for 'gap' cycles.
  task automatic send_bit(input logic b, input logic s, input int gap);
    x = b; x_valid = 1'b1; sof = s;
    tick();
    x_valid = 1'b0; sof = 1'b0;
    repeat (gap) tick();
  endtask

  // Eight data bits LSB first; optional gaps (i%4) and odd_mode toggle
  // after bit 3 to probe the latched parity sense.
  task automatic send_data(input logic [7:0] w, input logic sof0,
                           input bit gaps, input bit toggle);
    for (int i = 0; i < 8; i++) begin
      if (toggle && i == 4) odd_mode = ~odd_mode;
      send_bit(w[i], (i == 0) ? sof0 : 1'b0, gaps ? (i % 4) : 0);
    end
  endtask

  task automatic send_bit1(input logic b);
    x1 = b; x_valid1 = 1'b1; sof1 = 1'b0;
    tick();
    x_valid1 = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; x = 1'b0; x_valid = 1'b0; sof = 1'b0;
    odd_mode = PAR_EVEN; clr_count = 1'b0;
    x1 = 1'b0; x_valid1 = 1'b0; sof1 = 1'b0;
    tick(); tick();
    check("rst_z", {31'd0, z_a}, 0);
    check("rst_data", {24'd0, d_a}, 0);
    check("rst_wv", {31'd0, wv_a}, 0);
    check("rst_cnt", {24'd0, c_a}, 0);
    rst = 1'b0;
    tick();

    // 1: 0x0D even, parity 1 -> clean
    send_data(8'h0D, 1'b1, 0, 0);
    check("t1_z_before_par", {31'd0, z_a}, 1);
    check("t1_wv_before_par", {31'd0, wv_a}, 0);
    send_bit(1'b1, 1'b0, 0);
    check("t1_data", {24'd0, d_a}, 32'h0D);
    check("t1_wv", {31'd0, wv_a}, 1);
    check("t1_pe", {31'd0, pe_a}, 0);
    check("t1_cnt", {24'd0, c_a}, 0);
    check("t1_z_cleared", {31'd0, z_a}, 0);
    tick();
    check("t1_wv_pulse", {31'd0, wv_a}, 0);

    // 2: same frame parity 0 -> error; odd mode parity 0 -> clean
    send_data(8'h0D, 1'b0, 0, 0);
    send_bit(1'b0, 1'b0, 0);
    check("t2_wv", {31'd0, wv_a}, 1);
    check("t2_pe", {31'd0, pe_a}, 1);
    check("t2_cnt", {24'd0, c_a}, 1);
    tick();
    check("t2_pe_pulse", {31'd0, pe_a}, 0);
    odd_mode = PAR_ODD;
    send_data(8'h0D, 1'b0, 0, 0);
    odd_mode = PAR_EVEN;
    send_bit(1'b0, 1'b0, 0);
    check("t2_odd_wv", {31'd0, wv_a}, 1);
    check("t2_odd_pe", {31'd0, pe_a}, 0);
    check("t2_odd_cnt", {24'd0, c_a}, 1);

    // 3: abort after 5 bits, restart with sof, complete 0xA5
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 0);
    check("t3_z_partial", {31'd0, z_a}, 1);
    send_bit(1'b1, 1'b1, 0);
    check("t3_abort", {31'd0, fa_a}, 1);
    check("t3_abort_wv", {31'd0, wv_a}, 0);
    check("t3_abort_data", {24'd0, d_a}, 32'h0D);
    tick();
    check("t3_abort_pulse", {31'd0, fa_a}, 0);
    begin
      logic [7:0] w;
      w = 8'hA5;
      for (int i = 1; i < 8; i++) send_bit(w[i], 1'b0, 0);
    end
    check("t3_data_held", {24'd0, d_a}, 32'h0D);
    check("t3_fa_quiet", {31'd0, fa_a}, 0);
    send_bit(1'b0, 1'b0, 0);
    check("t3_data", {24'd0, d_a}, 32'hA5);
    check("t3_pe", {31'd0, pe_a}, 0);

    // 4: gaps + mid-frame mode toggle; latched odd mode governs
    odd_mode = PAR_ODD;
    send_data(8'h3C, 1'b0, 1, 1);
    check("t4_z", {31'd0, z_a}, 0);
    send_bit(1'b1, 1'b0, 0);
    check("t4_data", {24'd0, d_a}, 32'h3C);
    check("t4_wv", {31'd0, wv_a}, 1);
    check("t4_pe", {31'd0, pe_a}, 0);
    odd_mode = PAR_ODD;
    send_data(8'h3C, 1'b0, 1, 1);
    send_bit(1'b0, 1'b0, 0);
    check("t4_latched_pe", {31'd0, pe_a}, 1);
    check("t4_cnt_a", {24'd0, c_a}, 2);
    check("t4_cnt_b", {30'd0, c_b}, 2);
    odd_mode = PAR_EVEN;

    // 5: clear, then saturation on CNT_W=2, clear beats increment
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("t5_clr_a", {24'd0, c_a}, 0);
    check("t5_clr_b", {30'd0, c_b}, 0);
    for (int f = 1; f <= 5; f++) begin
      send_data(8'h00, 1'b0, 0, 0);
      send_bit(1'b1, 1'b0, 0);
      check($sformatf("t5_sat_b%0d", f), {30'd0, c_b}, (f < 3) ? f : 3);
      check($sformatf("t5_cnt_a%0d", f), {24'd0, c_a}, f);
    end
    send_data(8'h00, 1'b0, 0, 0);
    clr_count = 1'b1;
    send_bit(1'b1, 1'b0, 0);
    clr_count = 1'b0;
    check("t5_clr_pe", {31'd0, pe_a}, 1);
    check("t5_clr_win_a", {24'd0, c_a}, 0);
    check("t5_clr_win_b", {30'd0, c_b}, 0);

    // 6: reset mid-frame (with active inputs), then a clean frame
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 0);
    send_bit1(1'b1);
    rst = 1'b1; x = 1'b1; x_valid = 1'b1; sof = 1'b1;
    tick();
    check("t6_rst_z", {31'd0, z_a}, 0);
    check("t6_rst_fa", {31'd0, fa_a}, 0);
    check("t6_rst_data", {24'd0, d_a}, 0);
    check("t6_rst_wv", {31'd0, wv_a}, 0);
    check("t6_rst_c_z", {31'd0, z_c}, 0);
    rst = 1'b0; x_valid = 1'b0; sof = 1'b0;
    tick();
    check("t6_no_abort", {31'd0, fa_a}, 0);
    send_data(8'h96, 1'b0, 0, 0);
    send_bit(1'b0, 1'b0, 0);
    check("t6_data", {24'd0, d_a}, 32'h96);
    check("t6_wv", {31'd0, wv_a}, 1);
    check("t6_pe", {31'd0, pe_a}, 0);

    // 6b: DATA_BITS=1 back-to-back frames (1,1) (1,0) (0,0)
    send_bit1(1'b1);
    check("t6c_z1", {31'd0, z_c}, 1);
    check("t6c_wv_idle", {31'd0, wv_c}, 0);
    send_bit1(1'b1);
    check("t6c_wv1", {31'd0, wv_c}, 1);
    check("t6c_d1", {31'd0, d_c}, 1);
    check("t6c_pe1", {31'd0, pe_c}, 0);
    send_bit1(1'b1);
    check("t6c_wv_drop", {31'd0, wv_c}, 0);
    send_bit1(1'b0);
    check("t6c_wv2", {31'd0, wv_c}, 1);
    check("t6c_pe2", {31'd0, pe_c}, 1);
    check("t6c_cnt2", {24'd0, c_c}, 1);
    send_bit1(1'b0);
    send_bit1(1'b0);
    check("t6c_wv3", {31'd0, wv_c}, 1);
    check("t6c_d3", {31'd0, d_c}, 0);
    check("t6c_pe3", {31'd0, pe_c}, 0);
    check("t6c_fa", {31'd0, fa_c}, 0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
